// File: rtl/axil_slave_regbank_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels) between the register bank and its master.
interface axil_slave_regbank_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]            S_AXI_AWPROT;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]            S_AXI_ARPROT;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axil_slave_regbank.sv
// AXI4-Lite register bank: CTRL (self-clearing start bit), read-only STATUS, plain RW words.
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_slave_regbank #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  axil_slave_regbank_if.slave   s_axi,
  input  logic [DATA_WIDTH-1:0] status_i,
  output logic [DATA_WIDTH-1:0] ctrl_o,
  output logic                  start_o
);
  localparam int               IDX_W      = ADDR_WIDTH - 2;
  localparam logic [IDX_W:0]   NUM_REGS_C = (IDX_W + 1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
  localparam logic [1:0]       RESP_OKAY  = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0]       RESP_OOR   = 2'b10;
`else
  localparam logic [1:0]       RESP_OOR   = 2'b00;
`endif

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NUM_REGS_C);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0]   old_v,
    input logic [DATA_WIDTH-1:0]   new_v,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  unused_s;

  assign aw_hs_s  = s_axi.S_AXI_AWVALID & ~aw_full_q;
  assign w_hs_s   = s_axi.S_AXI_WVALID & ~w_full_q;
  assign ar_hs_s  = s_axi.S_AXI_ARVALID & ~rvalid_q;
  assign commit_s = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx_s = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign unused_s = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Read mux over the bank; STATUS comes straight from the live input.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word_s = rd_word_s | (regs_q[i] & {DATA_WIDTH{ar_idx_s == IDX_W'(i)}});
    end
    rd_word_s = (ar_idx_s == IDX_STATUS) ? status_i : rd_word_s;
  end

  // Next-state for holding registers, responses and the register bank.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    start_d   = 1'b0;
    regs_d    = regs_q;

    if (aw_hs_s) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
    end else if (commit_s) begin
      aw_full_d = 1'b0;
    end else begin
      aw_full_d = aw_full_q;
    end

    if (w_hs_s) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end else if (commit_s) begin
      w_full_d = 1'b0;
    end else begin
      w_full_d = w_full_q;
    end

    // A commit only happens while BVALID is low, so it never races the B handshake.
    if (commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = idx_in_range(aw_idx_q) ? RESP_OKAY : RESP_OOR;
      start_d  = (aw_idx_q == IDX_CTRL) & wstrb_q[0] & wdata_q[0];
    end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_s && (aw_idx_q == IDX_W'(i)) && (i != 1)) begin
        regs_d[i] = apply_strb(regs_q[i], wdata_q, wstrb_q);
      end else if (i == 0) begin
        regs_d[i] = {regs_q[i][DATA_WIDTH-1:1], 1'b0};
      end else begin
        regs_d[i] = regs_q[i];
      end
    end

    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      if (idx_in_range(ar_idx_s)) begin
        rdata_d = rd_word_s;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = {DATA_WIDTH{1'b0}};
        rresp_d = RESP_OOR;
      end
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State registers; reset drops any in-flight transaction without a response.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= {IDX_W{1'b0}};
      w_full_q  <= 1'b0;
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= 4'b0000;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      start_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      regs_q    <= regs_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = ~aw_full_q;
  assign s_axi.S_AXI_WREADY  = ~w_full_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = ~rvalid_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign ctrl_o              = regs_q[0];
  assign start_o             = start_q;
endmodule

// File: tb/tb_axil_slave_regbank.sv
// Directed bench for axil_slave_regbank: vector table plus hand-written multi-cycle sequences.
module tb_axil_slave_regbank;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] status_i;
  logic [31:0] ctrl_o;
  logic        start_o;
  int          n_vec;
  int          n_err;

  axil_slave_regbank_if #(.ADDR_WIDTH(6)) bus ();

  axil_slave_regbank #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (bus),
    .status_i     (status_i),
    .ctrl_o       (ctrl_o),
    .start_o      (start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_starts;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat, output int starts);
    logic aw_rdy, w_rdy;
    int   n;
    starts = 0;
    n = 0;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    while (!bus.S_AXI_BVALID && n < 50) begin
      aw_rdy = bus.S_AXI_AWREADY;
      w_rdy  = bus.S_AXI_WREADY;
      tick();
      n++;
      if (aw_rdy) bus.S_AXI_AWVALID = 1'b0;
      if (w_rdy) bus.S_AXI_WVALID = 1'b0;
      if (start_o) starts++;
    end
    lat  = n;
    resp = bus.S_AXI_BRESP;
    tick();
    if (start_o) starts++;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    logic ar_rdy;
    int   n;
    n = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    while (!bus.S_AXI_RVALID && n < 50) begin
      ar_rdy = bus.S_AXI_ARREADY;
      tick();
      n++;
      if (ar_rdy) bus.S_AXI_ARVALID = 1'b0;
    end
    lat  = n;
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    tick();
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [5:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    int          l;
    axi_read(addr, d, r, l);
    chk(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          l;
    int          s;

    n_vec = 0;
    n_err = 0;
    vecs[0]  = '{1'b1, 6'h08, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 0};
    vecs[1]  = '{1'b0, 6'h08, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 0};
    vecs[2]  = '{1'b1, 6'h0C, 32'h11223344, 4'hF, 32'h0, 2'b00, 0};
    vecs[3]  = '{1'b1, 6'h10, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00, 0};
    vecs[4]  = '{1'b0, 6'h0C, 32'h0, 4'h0, 32'h11223344, 2'b00, 0};
    vecs[5]  = '{1'b0, 6'h10, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00, 0};
    vecs[6]  = '{1'b1, 6'h04, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00, 0};
    vecs[7]  = '{1'b0, 6'h04, 32'h0, 4'h0, 32'h5A5A0001, 2'b00, 0};
    vecs[8]  = '{1'b1, 6'h14, 32'h12345678, 4'h0, 32'h0, 2'b00, 0};
    vecs[9]  = '{1'b0, 6'h14, 32'h0, 4'h0, 32'h00000000, 2'b00, 0};
    vecs[10] = '{1'b1, 6'h3C, 32'hA5A5A5A5, 4'hF, 32'h0, OOR, 0};
    vecs[11] = '{1'b0, 6'h3C, 32'h0, 4'h0, 32'h00000000, OOR, 0};
    vecs[12] = '{1'b1, 6'h1F, 32'h87654321, 4'hC, 32'h0, 2'b00, 0};
    vecs[13] = '{1'b0, 6'h1C, 32'h0, 4'h0, 32'h87650000, 2'b00, 0};
    vecs[14] = '{1'b1, 6'h20, 32'h11111111, 4'hF, 32'h0, OOR, 0};
    vecs[15] = '{1'b0, 6'h20, 32'h0, 4'h0, 32'h00000000, OOR, 0};
    vecs[16] = '{1'b0, 6'h08, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 0};
    vecs[17] = '{1'b1, 6'h00, 32'h80000000, 4'h8, 32'h0, 2'b00, 0};
    vecs[18] = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h80000000, 2'b00, 0};
    vecs[19] = '{1'b1, 6'h00, 32'h00000001, 4'hF, 32'h0, 2'b00, 1};
    vecs[20] = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h00000000, 2'b00, 0};
    vecs[21] = '{1'b1, 6'h00, 32'h00000001, 4'h0, 32'h0, 2'b00, 0};
    vecs[22] = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h00000000, 2'b00, 0};
    vecs[23] = '{1'b1, 6'h18, 32'h0BADF00D, 4'hF, 32'h0, 2'b00, 0};
    vecs[24] = '{1'b0, 6'h18, 32'h0, 4'h0, 32'h0BADF00D, 2'b00, 0};

    rst_n = 1'b0;
    status_i = 32'h5A5A0001;
    bus.S_AXI_AWADDR = 6'h00; bus.S_AXI_AWPROT = 3'b000; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = 32'h0; bus.S_AXI_WSTRB = 4'h0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = 6'h00; bus.S_AXI_ARPROT = 3'b000; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    repeat (3) tick();

    chk("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    chk("rst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd1);
    chk("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
    chk("rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd0);
    chk("rst_bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
    chk("rst_rresp", {30'd0, bus.S_AXI_RRESP}, 32'd0);
    chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    chk("rst_ctrl", ctrl_o, 32'd0);
    chk("rst_start", {31'd0, start_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, l, s);
        chk($sformatf("v%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
        chk($sformatf("v%0d_blat", i), l, 32'd2);
        chk($sformatf("v%0d_starts", i), s, vecs[i].exp_starts);
      end else begin
        axi_read(vecs[i].addr, d, r, l);
        chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
        chk($sformatf("v%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
        chk($sformatf("v%0d_rlat", i), l, 32'd1);
      end
    end
    chk("ctrl_o_after_start", ctrl_o, 32'h00000000);
    chk("arready_idle", {31'd0, bus.S_AXI_ARREADY}, 32'd1);

    status_i = 32'h00C0FFEE;
    read_expect("status_live", 6'h04, 32'h00C0FFEE);

    // W three cycles ahead of AW, single byte lane into a word holding 0x11223344.
    bus.S_AXI_WDATA = 32'h0000AA00; bus.S_AXI_WSTRB = 4'b0010;
    bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("wfirst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
    chk("wfirst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    tick();
    tick();
    chk("wfirst_no_b", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    bus.S_AXI_AWADDR = 6'h0C; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk("wfirst_b_wait", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    tick();
    chk("wfirst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    chk("wfirst_bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
    chk("wfirst_ready_back", {30'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd3);
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk("wfirst_bdone", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    read_expect("wfirst_rdata", 6'h0C, 32'h1122AA44);

    // Commit and AR to the same word on one edge: read sees the old value.
    bus.S_AXI_AWADDR = 6'h18; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h600DCAFE; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARADDR = 6'h18; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    chk("same_edge_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
    chk("same_edge_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    chk("same_edge_rdata", bus.S_AXI_RDATA, 32'h0BADF00D);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
    chk("same_edge_done", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
    read_expect("same_edge_new", 6'h18, 32'h600DCAFE);

    // BREADY held low: second write is latched but waits for the first B.
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h01010101; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    tick();
    chk("bp_first_b", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    bus.S_AXI_AWADDR = 6'h0C; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h02020202; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("bp_latched", {30'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd0);
    repeat (9) tick();
    chk("bp_b_held", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    read_expect("bp_not_committed", 6'h0C, 32'h1122AA44);
    chk("bp_b_still", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    chk("bp_b_gap", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    tick();
    chk("bp_second_b", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    chk("bp_ready_back", {30'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd3);
    tick();
    bus.S_AXI_BREADY = 1'b0;
    read_expect("bp_second_data", 6'h0C, 32'h02020202);
    read_expect("bp_first_data", 6'h08, 32'h01010101);

    // Reset asserted while B, a latched write and R are all pending.
    bus.S_AXI_AWADDR = 6'h00; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h40000000; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    tick();
    chk("mid_ctrl_set", ctrl_o, 32'h40000000);
    bus.S_AXI_AWADDR = 6'h10; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h33333333; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARADDR = 6'h08; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    chk("mid_pending", {29'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY}, 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
    chk("mid_rst_readys", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd7);
    chk("mid_rst_ctrl", ctrl_o, 32'd0);
    chk("mid_rst_rdata", bus.S_AXI_RDATA, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_no_resp", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
    read_expect("post_rst_r08", 6'h08, 32'd0);
    read_expect("post_rst_r0c", 6'h0C, 32'd0);
    read_expect("post_rst_r10", 6'h10, 32'd0);
    read_expect("post_rst_r1c", 6'h1C, 32'd0);
    read_expect("post_rst_r00", 6'h00, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axil_slave_regbank.md
Name: axil_slave_regbank

Overview:
- AXI4-Lite slave register bank; the downstream consumer of the AXI-Lite master IP's write/read transactions.
- Sits on the slave side of the AXI-Lite interconnect.
- Exposes DMA control/status registers: a CTRL register with a self-clearing start pulse, a read-only STATUS register, and general read/write registers.
- Serves as the synthesizable target for the master's test pattern in place of the slave VIP.

Parameters:
- ADDR_WIDTH, 6, byte-address width of AWADDR/ARADDR.
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- NUM_REGS, 8, number of 32-bit registers.
  - Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - NUM_REGS ≤ 2^(ADDR_WIDTH-2) and NUM_REGS ≥ 3.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- status_i  in  32  sampled live into STATUS (index 1)
- ctrl_o  out  32  current CTRL (index 0) contents
- start_o  out  1  one-cycle pulse when a write sets CTRL bit0

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. S_AXI_ARESETN is asynchronous assert, active-low; it is synchronised externally for deassertion.
- Reset values:
  - All registers = 0.
  - AWREADY = 1, WREADY = 1, ARREADY = 1.
  - BVALID = 0, RVALID = 0, BRESP = 0, RRESP = 0, RDATA = 0.
  - ctrl_o = 0, start_o = 0.
- Write channel:
  - AW and W are accepted independently, in either order, each into a one-entry holding register.
  - AWREADY = ~aw_full; WREADY = ~w_full. Both are registered flags.
  - Commit occurs at the first edge where aw_full & w_full & ~BVALID:
    - register updated per WSTRB byte lanes;
    - BVALID = 1 after that edge;
    - aw_full and w_full clear.
  - Minimum latency: AW+W handshake at edge N → commit and BVALID high after edge N+1.
  - BVALID/BRESP are held until BREADY. New AW/W may be accepted while BVALID=1, but the next commit waits until B completes.
- Read channel:
  - ARREADY = ~RVALID.
  - AR handshake at edge N → RDATA/RRESP registered and RVALID = 1 after edge N.
  - RDATA is held stable until RREADY; ARREADY returns to 1 the cycle after the R handshake.
- Register map (word index):
  - 0 CTRL: RW. A write with WSTRB[0]=1 and WDATA[0]=1 pulses start_o for exactly the commit cycle+1. CTRL bit0 self-clears on the following edge, so reads return bit0=0. Bits 31:1 are plain RW.
  - 1 STATUS: read-only; a read returns status_i sampled at the AR handshake edge. Writes complete with OKAY and have no effect.
  - 2..NUM_REGS-1: plain RW with byte strobes.
- Out-of-range index (≥ NUM_REGS): the write is dropped and the read returns 0. Response code per the optional feature.
- Simultaneous commit and AR to the same index on the same edge: RDATA returns the pre-write value.
- WSTRB = 0: write completes with OKAY and no register change; no start pulse.
- Reset mid-transaction: all holding flags, pending BVALID/RVALID and register contents clear immediately. No response is issued for the interrupted transaction.

Optional Feature:
- AXIL_SLVERR_EN defined: out-of-range write → BRESP = 2'b10 (SLVERR); out-of-range read → RRESP = 2'b10, RDATA = 0.
- AXIL_SLVERR_EN undefined: out-of-range accesses respond OKAY (2'b00); writes are silently dropped and reads return 0.
- In-range accesses are always OKAY.

Test Plan:
- Write 0xDEADBEEF to addr 0x08 with AW and W in the same cycle, BREADY=1 → BVALID after 2 edges with BRESP=0. Read 0x08 → RDATA=0xDEADBEEF, RRESP=0, RVALID one edge after AR.
- W presented 3 cycles before AW, then WSTRB=4'b0010 with WDATA=0x0000AA00 to 0x0C holding 0x11223344 → final read returns 0x1122AA44.
- Write 0x00000001 to 0x00 → start_o high exactly one cycle; subsequent read of 0x00 returns 0x00000000 and ctrl_o[0]=0.
- status_i=0x5A5A0001, write 0xFFFFFFFF to 0x04 → BRESP=0; read 0x04 returns 0x5A5A0001.
- Read/write addr 0x3C with NUM_REGS=8:
  - with AXIL_SLVERR_EN → BRESP=2, RRESP=2, RDATA=0;
  - without → both 0, RDATA=0;
  - registers 0..7 unchanged.
- Hold BREADY=0 for 10 cycles and issue a second AW+W → second pair latched (AWREADY/WREADY drop to 0), commit only after first B handshake. Assert ARESETN low mid-wait → all valids 0 and registers 0.
